pam_symbol_unpacker: RTL and testbench

Receive-side counterpart of the PAM level-select transmit path. Takes 5-bit left-justified amplitude samples, which carry an n-bit PAM symbol in the MSBs and zeros below. The block:
- rounds and slices each sample back to its symbol for the selected PAM order;
- packs the recovered symbol bits MSB-first into bytes;
- delivers the bytes over a valid/ready handshake.

It sits between the sample capture logic and the byte-oriented data sink.

---
 rtl/pam_symbol_unpacker.sv | 114 +++++++++++
 tb/tb_pam_symbol_unpacker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_symbol_unpacker.sv
// Receive-side PAM slicer: rounds left-justified 5-bit samples back to n-bit
// symbols, packs them MSB-first into bytes and hands them out over valid/ready.
module pam_symbol_unpacker (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [4:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       flush,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [1:0] mode_active
);

    // Handshake rule (both sides): a transfer happens on a rising edge where
    // valid && ready; the producer holds data and valid stable until then.

    logic [11:0] acc_q, acc_d;
    logic [3:0]  count_q, count_d;
    logic        flush_pending_q, flush_pending_d;
    logic [1:0]  mode_active_q, mode_active_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;

    logic [1:0]  mode_eff;
    logic [2:0]  k;
    logic [5:0]  rounded;
    logic [4:0]  saturated;
    logic [4:0]  symbol;
    logic        accept;
    logic        slot_free;
    logic [11:0] acc_shifted;
    logic [7:0]  remainder;

    // The slicing order may only change on an empty, byte-aligned accumulator.
    assign mode_eff  = (count_q == 4'd0) ? mode : mode_active_q;
    assign k         = {1'b0, mode_eff} + 3'd2;

    always_comb begin
        rounded   = 6'd0;
        saturated = 5'd0;
        symbol    = sample_in;
        if (k != 3'd5) begin
            rounded   = {1'b0, sample_in} + (6'd1 << (3'd4 - k));
            saturated = rounded[5] ? 5'h1F : rounded[4:0];
            symbol    = saturated >> (3'd5 - k);
        end
    end

    assign sample_ready = !rst && !flush_pending_q && (count_q <= 4'd7);
    assign accept       = sample_valid && sample_ready;
    assign slot_free    = !byte_valid_q || byte_ready;
    assign acc_shifted  = acc_q >> (count_q - 4'd8);
    assign remainder    = acc_q[7:0] << (4'd8 - count_q);

    always_comb begin
        acc_d           = acc_q;
        count_d         = count_q;
        flush_pending_d = flush_pending_q | flush;
        mode_active_d   = mode_eff;
        byte_out_d      = byte_out_q;
        byte_valid_d    = byte_valid_q;

        if (byte_ready) begin
            byte_valid_d = 1'b0;
        end

        if (accept) begin
            acc_d   = (acc_q << k) | {7'd0, symbol};
            count_d = count_q + {1'b0, k};
        end else if (count_q >= 4'd8) begin
            if (slot_free) begin
                byte_out_d   = acc_shifted[7:0];
                byte_valid_d = 1'b1;
                count_d      = count_q - 4'd8;
            end
        end else if (flush_pending_q) begin
            // Full bytes drain first; only a 1..7 bit tail is padded out here.
            if (count_q == 4'd0) begin
                flush_pending_d = 1'b0;
            end else if (slot_free) begin
                byte_out_d      = remainder;
                byte_valid_d    = 1'b1;
                count_d         = 4'd0;
                flush_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q           <= 12'd0;
            count_q         <= 4'd0;
            flush_pending_q <= 1'b0;
            mode_active_q   <= 2'd0;
            byte_out_q      <= 8'd0;
            byte_valid_q    <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            mode_active_q   <= mode_active_d;
            byte_out_q      <= byte_out_d;
            byte_valid_q    <= byte_valid_d;
        end
    end

    assign byte_out    = byte_out_q;
    assign byte_valid  = byte_valid_q;
    assign mode_active = mode_active_q;

endmodule

// File: tb/tb_pam_symbol_unpacker.sv
// Bench for pam_symbol_unpacker: directed scenarios plus random traffic scored
// against a bit-queue model of slicing, packing and flushing.
module tb_pam_symbol_unpacker;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [4:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       flush;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic [1:0] mode_active;

    pam_symbol_unpacker dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .flush        (flush),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mode_active  (mode_active)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         bq[$];          // symbol bits not yet formed into a byte
    logic [7:0] exp_q[$];       // bytes the sink must receive, in order
    logic [7:0] byte_log[$];    // every byte seen crossing the handshake
    logic [1:0] last_mode;      // order used for the most recent sample
    logic       prev_hold;
    logic [7:0] held_byte;
    logic       mode_chk;
    logic [1:0] mode_chk_val;

    function automatic int model_symbol(input int s, input int kk);
        int v;
        if (kk == 5) return s;
        v = (s + (1 << (4 - kk))) / (1 << (5 - kk));
        if (v > (1 << kk) - 1) v = (1 << kk) - 1;
        return v;
    endfunction

    task automatic model_take_bytes();
        logic [7:0] b;
        while (bq.size() >= 8) begin
            b = 8'd0;
            for (int i = 0; i < 8; i++) b = {b[6:0], bq.pop_front()};
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        int kk;
        int sym;
        logic [1:0] m;
        logic [7:0] b;
        if (rst) begin
            bq.delete();
            exp_q.delete();
            prev_hold = 1'b0;
            mode_chk  = 1'b0;
            last_mode = 2'd0;
        end else begin
            if (mode_chk) check("mode_active_after_accept", {30'd0, mode_active}, {30'd0, mode_chk_val});
            mode_chk = 1'b0;
            if (prev_hold) begin
                check("hold_valid", {31'd0, byte_valid}, 32'd1);
                check("hold_data", {24'd0, byte_out}, {24'd0, held_byte});
            end
            if (byte_valid && byte_ready) begin
                check("byte_expected_avail", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) check("byte_data", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
                byte_log.push_back(byte_out);
            end
            prev_hold = byte_valid && !byte_ready;
            held_byte = byte_out;

            if (sample_valid && sample_ready) begin
                m   = (bq.size() == 0) ? mode : last_mode;
                kk  = int'(m) + 2;
                sym = model_symbol(int'(sample_in), kk);
                for (int i = kk - 1; i >= 0; i--) bq.push_back(sym[i]);
                last_mode    = m;
                mode_chk     = 1'b1;
                mode_chk_val = m;
                model_take_bytes();
            end
            if (flush && bq.size() > 0) begin
                b = 8'd0;
                for (int i = 0; i < 8; i++) b = {b[6:0], (bq.size() > 0) ? bq.pop_front() : 1'b0};
                exp_q.push_back(b);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] m, input logic [4:0] s);
        mode         = m;
        sample_in    = s;
        sample_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sample_ready) break;
            if (i == 39) check("send_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst = 1'b1; mode = 2'd3; sample_in = 5'h1F; sample_valid = 1'b1;
        flush = 1'b0; byte_ready = 1'b1;

        // Reset held with traffic offered
        repeat (3) begin
            @(negedge clk);
            check("rst_sample_ready", {31'd0, sample_ready}, 32'd0);
            check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
            check("rst_byte_out", {24'd0, byte_out}, 32'd0);
            check("rst_mode_active", {30'd0, mode_active}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; sample_valid = 1'b0; mode = 2'd0;
        idle(2);

        // PAM-4 pack with exact latency
        base = byte_log.size();
        send(2'd0, 5'b11000);
        send(2'd0, 5'b01000);
        send(2'd0, 5'b10000);
        send(2'd0, 5'b00000);
        @(negedge clk);
        check("pam4_lat_edge1", {31'd0, byte_valid}, 32'd0);
        @(negedge clk);
        check("pam4_lat_edge2", {31'd0, byte_valid}, 32'd1);
        check("pam4_byte", {24'd0, byte_out}, 32'hD8);
        @(negedge clk);
        check("pam4_one_cycle", {31'd0, byte_valid}, 32'd0);
        check("pam4_logged", byte_log.size() - base, 32'd1);

        // PAM-8 rounding / saturation, one leftover bit flushed
        idle(1);
        base = byte_log.size();
        send(2'd1, 5'b01011);
        send(2'd1, 5'b11111);
        send(2'd1, 5'b00010);
        idle(3);
        check("pam8_count", byte_log.size() - base, 32'd1);
        if (byte_log.size() > base) check("pam8_byte", {24'd0, byte_log[base]}, 32'h7C);
        pulse_flush();
        idle(3);
        check("pam8_residual_count", byte_log.size() - base, 32'd2);
        if (byte_log.size() > base + 1) check("pam8_residual", {24'd0, byte_log[base+1]}, 32'h80);

        // PAM-32 straddle, four bits left behind
        base = byte_log.size();
        send(2'd3, 5'h1F);
        send(2'd3, 5'h00);
        send(2'd3, 5'h15);
        send(2'd3, 5'h1F);
        idle(3);
        check("pam32_count", byte_log.size() - base, 32'd2);
        if (byte_log.size() > base + 1) begin
            check("pam32_byte0", {24'd0, byte_log[base]}, 32'hF8);
            check("pam32_byte1", {24'd0, byte_log[base+1]}, 32'h2B);
        end
        pulse_flush();
        idle(3);
        if (byte_log.size() > base + 2) check("pam32_residual", {24'd0, byte_log[base+2]}, 32'hF0);
        else check("pam32_residual_missing", byte_log.size() - base, 32'd3);

        // Backpressure: second byte queued behind a held first byte
        byte_ready = 1'b0;
        send(2'd0, 5'b11000); send(2'd0, 5'b01000); send(2'd0, 5'b10000); send(2'd0, 5'b00000);
        send(2'd0, 5'b00000); send(2'd0, 5'b01000); send(2'd0, 5'b10000); send(2'd0, 5'b11000);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", {31'd0, byte_valid}, 32'd1);
            check("bp_data", {24'd0, byte_out}, 32'hD8);
            check("bp_sample_ready", {31'd0, sample_ready}, 32'd0);
        end
        @(posedge clk); #1;
        byte_ready = 1'b1;
        @(negedge clk);
        check("bp_release_first", {24'd0, byte_out}, 32'hD8);
        @(negedge clk);
        check("bp_second_valid", {31'd0, byte_valid}, 32'd1);
        check("bp_second_data", {24'd0, byte_out}, 32'h1B);

        // Mode change requested mid-byte
        idle(2);
        send(2'd0, 5'b11000);
        mode = 2'd2;
        repeat (3) begin
            @(negedge clk);
            check("mode_held", {30'd0, mode_active}, 32'd0);
        end
        @(posedge clk); #1;
        base = byte_log.size();
        send(2'd2, 5'b01000); send(2'd2, 5'b10000); send(2'd2, 5'b00000);
        idle(3);
        if (byte_log.size() > base) check("mode_held_byte", {24'd0, byte_log[base]}, 32'hD8);
        else check("mode_held_byte_missing", byte_log.size() - base, 32'd1);
        @(negedge clk);
        check("mode_switched", {30'd0, mode_active}, 32'd2);

        // Flush of a 4-bit remainder 1011
        @(posedge clk); #1;
        base = byte_log.size();
        send(2'd0, 5'b10000);
        send(2'd0, 5'b11000);
        pulse_flush();
        idle(3);
        if (byte_log.size() > base) check("flush_byte", {24'd0, byte_log[base]}, 32'hB0);
        else check("flush_byte_missing", byte_log.size() - base, 32'd1);
        @(negedge clk);
        check("flush_cleared_ready", {31'd0, sample_ready}, 32'd1);
        @(posedge clk); #1;

        // Random traffic with one mid-stream reset
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            rst          = (n >= 2000 && n < 2002);
            sample_valid = ($urandom_range(0, 3) != 0);
            sample_in    = 5'($urandom_range(0, 31));
            byte_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            flush        = !rst && sample_ready && ($urandom_range(0, 15) == 0);
        end

        // Drain everything, including any partial byte
        @(posedge clk); #1;
        rst = 1'b0; sample_valid = 1'b0; flush = 1'b0; byte_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sample_ready) break;
        end
        pulse_flush();
        idle(20);
        check("drain_empty", exp_q.size(), 32'd0);
        check("drain_idle_valid", {31'd0, byte_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
